// File: rtl/uart_pkg.sv
// Shared UART constants, frame timing helper and transmitter state type.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  // 8N1 frame: start, eight data bits, stop.
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  // Clock cycles per serial bit; integer division, shared with the receiver.
  function automatic int unsigned cycles_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word fall-through byte FIFO feeding the transmit shifter.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte intake, small FIFO, LSB-first shifter.
module uart_tx #(
  parameter int unsigned CLK_FREQ   = 12_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  import uart_pkg::*;

  localparam int unsigned CPB   = cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W = ($clog2(CPB) > 0) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  uart_tx_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic       bit_end;

  assign ready     = !fifo_full;
  assign fifo_push = valid && ready;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign bit_end   = (cnt_q == CNT_LAST);

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (data),
    .full (fifo_full),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .empty(fifo_empty)
  );

  // Shifter next-state: bit timing, byte pops and the next line level.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next frame so queued bytes leave no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level derived from the upcoming state keeps tx a clean register output.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Shifter state register; reset drops any frame in flight and idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three rate variants, one line monitor decoding frames.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld [3];
  logic [7:0] dat [3];
  logic       rdy [3];
  logic       txs [3];
  logic       bsy [3];

  always #5 clk = ~clk;

  // 0: 104 cycles/bit, 1: 10 cycles/bit (loopback), 2: 1250 cycles/bit.
  uart_tx #(.CLK_FREQ(12_000_000), .BAUD_RATE(115200), .FIFO_DEPTH(4)) u_main (
    .clk(clk), .rst(rst), .data(dat[0]), .valid(vld[0]), .ready(rdy[0]), .tx(txs[0]),
    .busy(bsy[0]));
  uart_tx #(.CLK_FREQ(1_152_000), .BAUD_RATE(115200), .FIFO_DEPTH(4)) u_fast (
    .clk(clk), .rst(rst), .data(dat[1]), .valid(vld[1]), .ready(rdy[1]), .tx(txs[1]),
    .busy(bsy[1]));
  uart_tx #(.CLK_FREQ(12_000_000), .BAUD_RATE(9600), .FIFO_DEPTH(4)) u_slow (
    .clk(clk), .rst(rst), .data(dat[2]), .valid(vld[2]), .ready(rdy[2]), .tx(txs[2]),
    .busy(bsy[2]));

  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  int         sel = 0;
  bit         mon_en = 1'b0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         frames = 0;
  logic       mon_tx;

  always @(posedge clk) cyc <= cyc + 1;
  always_comb mon_tx = txs[sel];

  function automatic int cpb_of(input int s);
    case (s)
      0:       return 104;
      1:       return 10;
      default: return 1250;
    endcase
  endfunction

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got == expv) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, expv, expv);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer a byte until accepted; the scoreboard entry is queued at the accepting edge.
  task automatic push(input int s, input logic [7:0] b, output int acc);
    int n;
    n = 0;
    dat[s] = b;
    vld[s] = 1'b1;
    @(negedge clk);
    while (!rdy[s] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[s]) begin
      check("push_timeout", 0, 1);
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_idle(input int s, input int budget, output int t);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bsy[s] && n < budget);
    if (bsy[s]) begin
      check("idle_timeout", 0, 1);
      t = -1;
    end else begin
      t = cyc;
    end
  endtask

  // Line monitor: checks every bit level at its first, middle and last cycle.
  initial begin : monitor
    int         e, cp;
    logic [7:0] exp_b, got;
    bit         shape_ok, have;
    logic       lvl;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !rst && mon_tx == 1'b0) begin
        e = cyc;
        cp = cpb_of(sel);
        starts.push_back(e);
        have = (exp_q.size() > 0);
        exp_b = have ? exp_q.pop_front() : 8'h00;
        shape_ok = 1'b1;
        got = 8'h00;
        for (int k = 0; k < 10; k++) begin
          if (k == 0) lvl = 1'b0;
          else if (k == 9) lvl = 1'b1;
          else lvl = exp_b[k-1];
          wait_to(e + k * cp);
          if (mon_tx !== lvl) shape_ok = 1'b0;
          wait_to(e + k * cp + cp / 2);
          if (mon_tx !== lvl) shape_ok = 1'b0;
          if (k >= 1 && k <= 8) got[k-1] = mon_tx;
          wait_to(e + k * cp + cp - 1);
          if (mon_tx !== lvl) shape_ok = 1'b0;
        end
        frames++;
        // Packed {expected-present, shape-ok, byte}: required is 0x3 followed by the byte.
        check("frame", int'({have, shape_ok, got}), int'({1'b1, 1'b1, exp_b}));
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a[6];
    int t, base, f0, lows;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      dat[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", int'(txs[0]), 1);
    check("rst_ready", int'(rdy[0]), 1);
    check("rst_busy", int'(bsy[0]), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single 0x55 frame: start latency and frame length.
    base = starts.size();
    push(0, 8'h55, a[0]);
    vld[0] = 1'b0;
    wait_idle(0, 2000, t);
    check("t1_start_edge", (starts.size() > base) ? starts[base] : -1, a[0] + 1);
    check("t1_idle_edge", t, a[0] + 1041);
    check("t1_tx_idle", int'(txs[0]), 1);

    // Back-to-back frames with valid held high.
    base = starts.size();
    push(0, 8'hA5, a[0]);
    push(0, 8'h3C, a[1]);
    push(0, 8'hFF, a[2]);
    push(0, 8'h00, a[3]);
    vld[0] = 1'b0;
    check("t2_accept_span", a[3] - a[0], 3);
    wait_idle(0, 6000, t);
    check("t2_frames", starts.size() - base, 4);
    for (int i = 1; i < 4; i++)
      check("t2_gap", (starts.size() > base + i) ? starts[base+i] - starts[base+i-1] : -1, 1040);
    check("t2_line_cycles", (starts.size() > base) ? t - starts[base] : -1, 4160);

    // Overfill: five taken immediately, sixth waits for the first STOP pop.
    f0 = frames;
    for (int i = 0; i < 5; i++) push(0, 8'(8'h11 * (i + 1)), a[i]);
    check("t3_five_span", a[4] - a[0], 4);
    dat[0] = 8'h66;
    @(negedge clk);
    check("t3_ready_low", int'(rdy[0]), 0);
    push(0, 8'h66, a[5]);
    vld[0] = 1'b0;
    check("t3_sixth_edge", a[5] - a[0], 1042);
    wait_idle(0, 8000, t);
    check("t3_frames", frames - f0, 6);
    check("t3_queue_empty", exp_q.size(), 0);

    // Reset during data bit 3 of 0x81 with two bytes queued.
    mon_en = 1'b0;
    push(0, 8'h81, a[0]);
    push(0, 8'h12, a[1]);
    push(0, 8'h34, a[2]);
    vld[0] = 1'b0;
    exp_q.delete();
    wait_to(a[0] + 1 + 4 * 104 + 50);
    check("t4_pre_tx", int'(txs[0]), 0);
    check("t4_pre_busy", int'(bsy[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t4_rst_tx", int'(txs[0]), 1);
    check("t4_rst_ready", int'(rdy[0]), 1);
    check("t4_rst_busy", int'(bsy[0]), 0);
    lows = 0;
    repeat (1100) begin
      @(posedge clk);
      #1;
      if (txs[0] !== 1'b1) lows++;
    end
    check("t4_line_high", lows, 0);
    check("t4_busy_after", int'(bsy[0]), 0);
    mon_en = 1'b1;

    // Loopback-style decode of all 256 byte values with random valid gaps.
    sel = 1;
    f0 = frames;
    for (int i = 0; i < 256; i++) begin
      push(1, 8'(i), a[0]);
      vld[1] = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle(1, 5000, t);
    check("t5_frames", frames - f0, 256);
    check("t5_queue_empty", exp_q.size(), 0);

    // 9600 baud variant: 1250-cycle bits.
    sel = 2;
    base = starts.size();
    push(2, 8'hC5, a[0]);
    vld[2] = 1'b0;
    wait_idle(2, 14000, t);
    check("t6_start_edge", (starts.size() > base) ? starts[base] : -1, a[0] + 1);
    check("t6_idle_edge", t, a[0] + 12501);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
